// File: rtl/fifo_n_pop_sched.sv
// Pop scheduler for the multi-VQ FIFO: round-robin selection over non-empty,
// enabled VQs, credit-limited so that every pop has a guaranteed slot in the
// small output buffer that absorbs the FIFO's one-cycle read latency.
//
// Output stream handshake: a beat transfers in any cycle where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// head entry (out_vq/out_data) is held stable, and out_valid never drops
// without a transfer except on reset.
module fifo_n_pop_sched #(
   parameter int VQ_N  = 8,
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [VQ_N-1:0]         vq_en,
   input  logic [VQ_N-1:0]         empty_i,
   output logic                    pop,
   output logic [$clog2(VQ_N)-1:0] pop_vq,
   input  logic                    pop_data_valid_r,
   input  logic [$clog2(VQ_N)-1:0] pop_data_vq_r,
   input  logic [W-1:0]            pop_data_w,
   output logic                    out_valid,
   output logic [$clog2(VQ_N)-1:0] out_vq,
   output logic [W-1:0]            out_data,
   input  logic                    out_ready,
   output logic                    err_r
);

   localparam int VW = $clog2(VQ_N);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [VQ_N-1:0] elig;
   logic [VW-1:0]   grant;
   logic            found;
   logic            deq;
   logic            allowed;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_deq;
   logic [VW-1:0]   rr_ptr_r;
   logic [VW-1:0]   rr_ptr_d;
   logic            infl_r;
   logic [VW-1:0]   infl_vq_r;

   // Buffer pointers carry a wrap bit on top so full and empty are distinguishable.
   logic [VW-1:0]   vq_mem_q   [DEPTH];
   logic [W-1:0]    data_mem_q [DEPTH];
   logic [PW:0]     rd_q;
   logic [PW:0]     wr_q;
   logic            buf_empty;
   logic            buf_full;
   logic            wr;
   logic            wr_ok;

   function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
      if (p[PW-1:0] == PW'(DEPTH - 1)) return {~p[PW], PW'(0)};
      else                             return {p[PW], p[PW-1:0] + PW'(1)};
   endfunction

   assign elig      = vq_en & ~empty_i;
   assign buf_empty = (rd_q == wr_q);
   assign buf_full  = (rd_q[PW-1:0] == wr_q[PW-1:0]) && (rd_q[PW] != wr_q[PW]);
   assign out_valid = ~buf_empty;
   assign out_vq    = vq_mem_q[rd_q[PW-1:0]];
   assign out_data  = data_mem_q[rd_q[PW-1:0]];
   assign deq       = out_valid & out_ready;
   // A dequeue this cycle frees a credit for a pop in the same cycle.
   assign cnt_deq   = cnt_r - CW'(deq);
   assign allowed   = cnt_deq < CW'(DEPTH);
   // Gated by rst_n so the strobe drops the moment reset is asserted.
   assign pop       = rst_n & found & allowed;
   assign pop_vq    = pop ? grant : '0;
   assign rr_ptr_d  = VW'((32'(grant) + 32'd1) % 32'(VQ_N));
   assign wr        = pop_data_valid_r & infl_r;
   assign wr_ok     = wr & (~buf_full | deq);

   // Round-robin grant: first eligible VQ at or above rr_ptr_r, wrapping.
   always_comb begin
      logic [VW-1:0] idx;
      idx   = '0;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < VQ_N; i++) begin
         idx = VW'((32'(rr_ptr_r) + 32'(i)) % 32'(VQ_N));
         if (!found && elig[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   // Scheduler state: priority pointer, credit count and in-flight tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r  <= '0;
         cnt_r     <= '0;
         infl_r    <= 1'b0;
         infl_vq_r <= '0;
      end else begin
         cnt_r  <= cnt_deq + CW'(pop);
         infl_r <= pop;
         if (pop) begin
            rr_ptr_r  <= rr_ptr_d;
            infl_vq_r <= grant;
         end
      end
   end

   // Output buffer: tail write on legitimate returns, head advance on dequeue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
         wr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            vq_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
      end else begin
         if (deq) rd_q <= ptr_inc(rd_q);
         if (wr_ok) begin
            vq_mem_q[wr_q[PW-1:0]]   <= pop_data_vq_r;
            data_mem_q[wr_q[PW-1:0]] <= pop_data_w;
            wr_q                     <= ptr_inc(wr_q);
         end
      end
   end

   // Sticky protocol error: orphan return, missing return, VQ mismatch, overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if ((pop_data_valid_r & ~infl_r) |
                   (infl_r & ~pop_data_valid_r) |
                   (wr & (pop_data_vq_r != infl_vq_r)) |
                   (wr & buf_full & ~deq)) begin
         err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_n_pop_sched.sv
// Bench for fifo_n_pop_sched: directed phases plus a random phase, checked
// against a queue-based model of the scheduling and buffering rules.
module tb_fifo_n_pop_sched;

   localparam int VQ_N  = 8;
   localparam int W     = 32;
   localparam int DEPTH = 2;
   localparam int VW    = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [VQ_N-1:0] vq_en;
   logic [VQ_N-1:0] empty_i;
   logic            pop;
   logic [VW-1:0]   pop_vq;
   logic            pop_data_valid_r;
   logic [VW-1:0]   pop_data_vq_r;
   logic [W-1:0]    pop_data_w;
   logic            out_valid;
   logic [VW-1:0]   out_vq;
   logic [W-1:0]    out_data;
   logic            out_ready;
   logic            err_r;

   fifo_n_pop_sched #(.VQ_N(VQ_N), .W(W), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .vq_en            (vq_en),
      .empty_i          (empty_i),
      .pop              (pop),
      .pop_vq           (pop_vq),
      .pop_data_valid_r (pop_data_valid_r),
      .pop_data_vq_r    (pop_data_vq_r),
      .pop_data_w       (pop_data_w),
      .out_valid        (out_valid),
      .out_vq           (out_vq),
      .out_data         (out_data),
      .out_ready        (out_ready),
      .err_r            (err_r)
   );

   // Clock: rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model state
   logic [VW+W-1:0] exp_q[$];
   bit              infl_m;
   int              infl_vq_m;
   int              rr_m;
   bit              err_m;

   // Return-path override for error injection, fixed data for directed checks
   bit              ovr_en;
   bit              ovr_v;
   logic [VW-1:0]   ovr_vq;
   bit              fix_en;
   logic [W-1:0]    fix_d;

   // Values observed in the last cycle() call
   logic            obs_pop;
   logic [VW-1:0]   obs_vq;
   logic            obs_valid;
   logic [VW-1:0]   obs_out_vq;
   logic [W-1:0]    obs_out_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [VQ_N-1:0] elig, input int rr);
      for (int k = 0; k < VQ_N; k++)
         if (elig[(rr + k) % VQ_N]) return (rr + k) % VQ_N;
      return -1;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      infl_m    = 0;
      infl_vq_m = 0;
      rr_m      = 0;
      err_m     = 0;
      ovr_en    = 0;
      fix_en    = 0;
   endtask

   // One clock cycle: drive inputs and FIFO return, check outputs, advance model.
   // Entered and left at rising edge + 1.
   task automatic cycle(input logic [VQ_N-1:0] en, input logic [VQ_N-1:0] emp, input bit rdy);
      bit  exp_valid, deq, allowed, pop_m;
      int  g, cnt_m;
      logic [VW+W-1:0] head;
      vq_en     = en;
      empty_i   = emp;
      out_ready = rdy;
      if (ovr_en) begin
         pop_data_valid_r = ovr_v;
         pop_data_vq_r    = ovr_vq;
      end else begin
         pop_data_valid_r = infl_m;
         pop_data_vq_r    = VW'(infl_vq_m);
      end
      pop_data_w = fix_en ? fix_d : W'($urandom);
      #2;
      exp_valid = (exp_q.size() > 0);
      deq       = exp_valid && rdy;
      obs_pop      = pop;
      obs_vq       = pop_vq;
      obs_valid    = out_valid;
      obs_out_vq   = out_vq;
      obs_out_data = out_data;
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         head = exp_q[0];
         chk("out_vq", out_vq, head[VW+W-1:W]);
         chk("out_data", out_data, head[W-1:0]);
      end
      g       = model_grant(en & ~emp, rr_m);
      cnt_m   = exp_q.size() + (infl_m ? 1 : 0);
      allowed = (cnt_m - (deq ? 1 : 0)) < DEPTH;
      pop_m   = (g >= 0) && allowed;
      chk("pop", pop, pop_m);
      chk("pop_vq", pop_vq, pop_m ? g : 0);
      chk("err_r", err_r, err_m);
      @(posedge clk);
      #1;
      if (deq) void'(exp_q.pop_front());
      if (pop_data_valid_r) begin
         if (infl_m) begin
            if (int'(pop_data_vq_r) != infl_vq_m) err_m = 1;
            exp_q.push_back({pop_data_vq_r, pop_data_w});
         end else begin
            err_m = 1;
         end
      end else if (infl_m) begin
         err_m = 1;
      end
      infl_m = pop_m;
      if (pop_m) begin
         infl_vq_m = g;
         rr_m      = (g + 1) % VQ_N;
      end
      ovr_en = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) cycle('1, '1, 1'b1);
   endtask

   // Assert reset between edges, release between edges; leaves at edge + 1.
   task automatic do_reset();
      rst_n            = 1'b0;
      pop_data_valid_r = 1'b0;
      empty_i          = '1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   initial begin
      int npop;
      rst_n            = 1'b0;
      vq_en            = '1;
      empty_i          = '0;
      out_ready        = 1'b1;
      pop_data_valid_r = 1'b0;
      pop_data_vq_r    = '0;
      pop_data_w       = '0;
      model_clear();

      // Reset values (empty_i all clear so pop must be held off by reset alone)
      #3;
      chk("rst_pop", pop, 0);
      chk("rst_pop_vq", pop_vq, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_vq", out_vq, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err_r, 0);
      chk("rst_cnt", dut.cnt_r, 0);
      chk("rst_rr", dut.rr_ptr_r, 0);
      do_reset();

      // Single VQ: pop VQ0, return A5, visible two cycles after the pop
      cycle(8'hFF, 8'hFE, 1'b1);
      chk("single_pop", obs_pop, 1);
      chk("single_pop_vq", obs_vq, 0);
      fix_en = 1; fix_d = 32'hA5;
      cycle(8'hFF, 8'hFF, 1'b1);
      fix_en = 0;
      chk("single_no_early_valid", obs_valid, 0);
      cycle(8'hFF, 8'hFF, 1'b1);
      chk("single_valid", obs_valid, 1);
      chk("single_vq", obs_out_vq, 0);
      chk("single_data", obs_out_data, 32'hA5);
      drain();
      do_reset();

      // Round-robin with full throughput
      for (int i = 0; i < 10; i++) begin
         cycle(8'hFF, 8'h00, 1'b1);
         chk("rr_pop", obs_pop, 1);
         chk("rr_seq", obs_vq, i % VQ_N);
      end
      drain();
      do_reset();

      // Backpressure: only DEPTH pops, then resume with no loss
      npop = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(8'hFF, 8'h00, 1'b0);
         if (obs_pop) npop++;
      end
      chk("bp_pops", npop, DEPTH);
      chk("bp_cnt", dut.cnt_r, DEPTH);
      for (int i = 0; i < 12; i++) cycle(8'hFF, 8'h00, 1'b1);
      drain();
      chk("bp_drained", exp_q.size(), 0);
      do_reset();

      // Mask and wrap: rr_ptr_r=1 then enable only VQ7 and VQ0
      cycle(8'h01, 8'h00, 1'b1);
      chk("mask_rr", dut.rr_ptr_r, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(8'h81, 8'h00, 1'b1);
         chk("mask_seq", obs_vq, (i % 2 == 0) ? 7 : 0);
      end
      drain();
      do_reset();

      // Error: orphan return is dropped and flags err_r
      ovr_en = 1; ovr_v = 1; ovr_vq = 3'd2;
      cycle(8'hFF, 8'hFF, 1'b1);
      cycle(8'hFF, 8'hFF, 1'b1);
      chk("err_orphan", err_r, 1);
      chk("err_orphan_empty", obs_valid, 0);
      do_reset();
      chk("err_cleared", err_r, 0);

      // Error: VQ mismatch on a legitimate return
      cycle(8'hFF, 8'hF7, 1'b1);
      chk("mm_pop_vq", obs_vq, 3);
      ovr_en = 1; ovr_v = 1; ovr_vq = 3'd5;
      cycle(8'hFF, 8'hFF, 1'b1);
      cycle(8'hFF, 8'hFF, 1'b1);
      chk("err_mismatch", err_r, 1);
      drain();
      do_reset();

      // Random traffic
      for (int i = 0; i < 300; i++)
         cycle(VQ_N'($urandom), VQ_N'($urandom), 1'($urandom_range(0, 3) != 0));
      drain();
      chk("rand_err", err_r, 0);
      do_reset();

      // Reset mid-stream with two entries buffered
      for (int i = 0; i < 3; i++) cycle(8'hFF, 8'h00, 1'b0);
      chk("mid_buffered", exp_q.size(), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_out_valid", out_valid, 0);
      chk("mid_pop", pop, 0);
      empty_i = '1;
      pop_data_valid_r = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      chk("mid_cnt", dut.cnt_r, 0);
      chk("mid_out_valid_after", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
